uart_rx_monitor: RTL

//  Parametrised UART receive monitor for the Verilator/SV top-level benches: samples a SoC uart_tx line,

---
 rtl/uart_rx_monitor_pkg.sv | 33 +++
 rtl/uart_rx_monitor_core.sv | 178 +++++++++++++++++
 rtl/uart_rx_monitor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_rx_monitor_pkg.sv
// uart_rx_monitor_pkg
// Shared types for the UART receive monitor: FSM state encoding, the decoded
// character record stored in the FIFO, the per-frame latched configuration,
// and the helper that turns the 2-bit data-length code into a bit count.
package uart_rx_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } char_t;

  typedef struct packed {
    logic [3:0] nBits;
    logic       parityEn;
    logic       parityOdd;
    logic       stop2;
  } cfg_t;

  // 00=5, 01=6, 10=7, 11=8 data bits
  function automatic logic [3:0] bits_from_cfg(input logic [1:0] sel);
    return 4'd5 + {2'b00, sel};
  endfunction

endpackage

// File: rtl/uart_rx_monitor_core.sv
// uart_rx_monitor_core
// Serial front end of the UART receive monitor: two-flop synchroniser on the
// asynchronous line, falling-edge detect, frame FSM with baud and bit
// counters. Emits one decoded character plus a one-cycle strobe in the cycle
// after the final stop-bit sample; the FSM is already back in IDLE then.
import uart_rx_monitor_pkg::*;

module uart_rx_monitor_core #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             rx_i,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_parity_odd_i,
  input  logic             cfg_stop2_i,
  output char_t            char_o,
  output logic             char_valid_o,
  output logic             busy_o
);

  logic             sync1_q, sync2_q, rxPrev_q;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] baudCnt_q, baudCnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  cfg_t             cfg_q, cfg_d;
  logic [7:0]       data_q, data_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  char_t            charOut_q, charOut_d;
  logic             charValid_q, charValid_d;

  logic fallEdge;
  logic tick;
  logic sample;

  // A high-to-low transition seen after synchronisation. Because rxPrev_q
  // follows the line in every state, a frame that ends with the line still low
  // cannot retrigger until the line has gone high again.
  assign fallEdge = rxPrev_q & ~sync2_q;
  assign tick     = (baudCnt_q == '0);
  assign sample   = sync2_q;

  // Two-flop synchroniser plus edge-detect history; idle-high after reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      rxPrev_q <= sync2_q;
    end
  end

  // Frame FSM: half-bit wait to the start-bit centre, then one sample per bit
  always_comb begin
    state_d     = state_q;
    baudCnt_d   = baudCnt_q;
    div_d       = div_q;
    bitCnt_d    = bitCnt_q;
    cfg_d       = cfg_q;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    charOut_d   = charOut_q;
    charValid_d = 1'b0;

    if (!cfg_en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fallEdge) begin
            state_d         = START;
            cfg_d.nBits     = bits_from_cfg(cfg_bits_i);
            cfg_d.parityEn  = cfg_parity_en_i;
            cfg_d.parityOdd = cfg_parity_odd_i;
            cfg_d.stop2     = cfg_stop2_i;
            div_d           = cfg_div_i;
            baudCnt_d       = (cfg_div_i >> 1) - DIV_W'(1);
            bitCnt_d        = 4'd0;
            data_d          = 8'h00;
            perr_d          = 1'b0;
            ferr_d          = 1'b0;
          end
        end
        START: begin
          if (tick) begin
            baudCnt_d = div_q - DIV_W'(1);
            if (sample) state_d = IDLE;
            else        state_d = DATA;
          end else begin
            baudCnt_d = baudCnt_q - DIV_W'(1);
          end
        end
        DATA: begin
          if (tick) begin
            baudCnt_d                = div_q - DIV_W'(1);
            data_d[bitCnt_q[2:0]]    = sample;
            if (bitCnt_q == cfg_q.nBits - 4'd1) begin
              bitCnt_d = 4'd0;
              state_d  = cfg_q.parityEn ? PARITY : STOP;
            end else begin
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end else begin
            baudCnt_d = baudCnt_q - DIV_W'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            baudCnt_d = div_q - DIV_W'(1);
            perr_d    = ((^data_q) ^ sample) != cfg_q.parityOdd;
            state_d   = STOP;
          end else begin
            baudCnt_d = baudCnt_q - DIV_W'(1);
          end
        end
        STOP: begin
          if (tick) begin
            baudCnt_d = div_q - DIV_W'(1);
            ferr_d    = ferr_q | ~sample;
            if (!cfg_q.stop2 || bitCnt_q == 4'd1) begin
              state_d        = IDLE;
              charValid_d    = 1'b1;
              charOut_d.ferr = ferr_q | ~sample;
              charOut_d.perr = perr_q;
              charOut_d.data = data_q;
            end else begin
              bitCnt_d = 4'd1;
            end
          end else begin
            baudCnt_d = baudCnt_q - DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame state registers; reset discards any frame in flight
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      baudCnt_q   <= '0;
      div_q       <= '0;
      bitCnt_q    <= 4'd0;
      cfg_q       <= '0;
      data_q      <= 8'h00;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      charOut_q   <= '0;
      charValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baudCnt_q   <= baudCnt_d;
      div_q       <= div_d;
      bitCnt_q    <= bitCnt_d;
      cfg_q       <= cfg_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      charOut_q   <= charOut_d;
      charValid_q <= charValid_d;
    end
  end

  assign char_o       = charOut_q;
  assign char_valid_o = charValid_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
// UART receive monitor top: decodes the serial line via uart_rx_monitor_core,
// buffers characters with error flags in a first-word-fall-through FIFO,
// and keeps saturating frame / error counters plus a sticky overflow flag.
// Optional feature macro: UART_RX_MONITOR_PRINT_EN echoes each received
// character to the simulation log (simulation only, absent by default).
import uart_rx_monitor_pkg::*;

module uart_rx_monitor #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          rx_i,
  input  logic                          cfg_en_i,
  input  logic [DIV_W-1:0]              cfg_div_i,
  input  logic [1:0]                    cfg_bits_i,
  input  logic                          cfg_parity_en_i,
  input  logic                          cfg_parity_odd_i,
  input  logic                          cfg_stop2_i,
  input  logic                          clr_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [7:0]                    data_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic [CNT_W-1:0]              frame_cnt_o,
  output logic [CNT_W-1:0]              err_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  char_t          charIn;
  logic           charValid;
  char_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wrPtr_q, rdPtr_q;
  logic [AW:0]    count_q;
  logic           overflow_q;
  logic [CNT_W-1:0] frameCnt_q, errCnt_q;
  logic           full, pop, doWrite;
  char_t          head;

  uart_rx_monitor_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .rx_i             (rx_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .char_o           (charIn),
    .char_valid_o     (charValid),
    .busy_o           (busy_o)
  );

  // A push into a full FIFO only lands when a pop frees the head slot that cycle
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = valid_o & ready_i;
  assign doWrite = charValid & (~full | pop);
  assign head    = mem_q[rdPtr_q];

  // Character storage; contents need no reset because count_q qualifies them
  always_ff @(posedge clk_i) begin
    if (doWrite) mem_q[wrPtr_q] <= charIn;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)     rdPtr_q <= rdPtr_q + AW'(1);
      unique case ({doWrite, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky drop flag and saturating counters; clear has priority over increments
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_q <= 1'b0;
      frameCnt_q <= '0;
      errCnt_q   <= '0;
    end else if (clr_i) begin
      overflow_q <= 1'b0;
      frameCnt_q <= '0;
      errCnt_q   <= '0;
    end else if (charValid) begin
      if (full && !pop)       overflow_q <= 1'b1;
      if (frameCnt_q != '1)   frameCnt_q <= frameCnt_q + CNT_W'(1);
      if ((charIn.ferr || charIn.perr) && errCnt_q != '1)
        errCnt_q <= errCnt_q + CNT_W'(1);
    end
  end

  assign valid_o     = (count_q != '0);
  assign data_o      = valid_o ? head.data : 8'h00;
  assign perr_o      = valid_o & head.perr;
  assign ferr_o      = valid_o & head.ferr;
  assign level_o     = count_q;
  assign overflow_o  = overflow_q;
  assign frame_cnt_o = frameCnt_q;
  assign err_cnt_o   = errCnt_q;

`ifdef UART_RX_MONITOR_PRINT_EN
  // Echo every decoded character into the simulation log as it is pushed
  always @(posedge clk_i) begin
    if (rstn_i && charValid) begin
      if (!charIn.ferr && !charIn.perr) $write("%c", charIn.data);
      else $display("uart_rx_monitor: parity/framing error 0x%02h", charIn.data);
    end
  end
`endif

endmodule
